set_scheduler: RTL and testbench

SET_SCHEDULER -- requirements
Module: set_scheduler

---
 rtl/set_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_set_scheduler.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/set_scheduler.sv
// set_scheduler: sequences commands into a set-membership engine, scans an
// 8x8 grid in raster order and counts the coordinates the engine marks as hits.
//
// Optional build macro SET_SCHED_FIFO_EN:
//   undefined - a single holding register stores one pending command.
//   defined   - a 4-entry FIFO stores pending commands.
//
// state | meaning
// IDLE  | waiting for a stored command
// LOAD  | command popped to the engine, start pulsed, counter and index cleared
// SCAN  | 64 cycles presenting grid coordinates and counting hits
// DONE  | result_o valid for one cycle

module set_scheduler #(
  parameter int CMD_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [CMD_W-1:0] cmd_i,
  output logic             eng_start_o,
  output logic [CMD_W-1:0] eng_cmd_o,
  output logic             coord_en_o,
  output logic [2:0]       coord_x_o,
  output logic [2:0]       coord_y_o,
  input  logic             hit_i,
  output logic [6:0]       result_o,
  output logic             valid_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [5:0]       idx;
  logic [6:0]       cnt;
  logic [CMD_W-1:0] cmd_reg;
  logic             live;
  logic             push;
  logic             pop;
  logic             stored;
  logic [CMD_W-1:0] head;

  // Handshake and pop: LOAD is the only cycle that removes a stored command.
  assign push = cmd_valid_i && cmd_ready_o;
  assign pop  = (state == LOAD);

  // Held low through reset so cmd_ready_o is 0 until the first edge after release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      live <= 1'b0;
    end else begin
      live <= 1'b1;
    end
  end

`ifdef SET_SCHED_FIFO_EN
  logic [CMD_W-1:0] mem [4];
  logic [1:0]       wr_ptr;
  logic [1:0]       rd_ptr;
  logic [2:0]       count;
  logic             full;

  assign full        = (count == 3'd4);
  assign stored      = (count != 3'd0);
  assign head        = mem[rd_ptr];
  assign cmd_ready_o = live && !full;

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= cmd_i;
    end
  end

  // FIFO pointers and occupancy; a push and a pop in the same cycle both apply.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end
`else
  logic [CMD_W-1:0] hold;
  logic             held;

  assign stored      = held;
  assign head        = hold;
  assign cmd_ready_o = live && (state == IDLE) && !held;

  // Single holding register; accepted only in IDLE, released in LOAD.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold <= '0;
      held <= 1'b0;
    end else if (push) begin
      hold <= cmd_i;
      held <= 1'b1;
    end else if (pop) begin
      held <= 1'b0;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; SCAN ends on the index wrap 63 -> 0.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (stored) state_next = LOAD;
      LOAD:    state_next = SCAN;
      SCAN:    if (idx == 6'd63) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Command register: captured on entry to LOAD so it is valid with the start
  // pulse, then left untouched until the next command is launched.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cmd_reg <= '0;
    end else if ((state == IDLE) && stored) begin
      cmd_reg <= head;
    end
  end

  // Grid index and hit counter; the counter keeps its final value after SCAN
  // and is only cleared by the next LOAD.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx <= 6'd0;
      cnt <= 7'd0;
    end else begin
      case (state)
        LOAD: begin
          idx <= 6'd0;
          cnt <= 7'd0;
        end
        SCAN: begin
          idx <= idx + 6'd1;
          if (hit_i) begin
            cnt <= cnt + 7'd1;
          end
        end
        default: begin
          idx <= idx;
          cnt <= cnt;
        end
      endcase
    end
  end

  // Output decode straight from the state and datapath registers.
  always_comb begin
    eng_start_o = (state == LOAD);
    coord_en_o  = (state == SCAN);
    valid_o     = (state == DONE);
    busy_o      = (state != IDLE);
    eng_cmd_o   = cmd_reg;
    result_o    = cnt;
    coord_x_o   = idx[2:0];
    coord_y_o   = idx[5:3];
  end

endmodule

// File: tb/tb_set_scheduler.sv
// Testbench for set_scheduler. Stimulus pushes the expected command word,
// hit count and DONE cycle into a scoreboard; a monitor on the falling edge
// checks start pulses, raster order and results as the DUT presents them.
// Build with +define+SET_SCHED_FIFO_EN to exercise the FIFO variant.

module tb_set_scheduler;

  localparam int CMD_W = 16;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             cmd_valid_i = 1'b0;
  logic [CMD_W-1:0] cmd_i = '0;
  logic             hit_i = 1'b0;
  logic             cmd_ready_o;
  logic             eng_start_o;
  logic [CMD_W-1:0] eng_cmd_o;
  logic             coord_en_o;
  logic [2:0]       coord_x_o;
  logic [2:0]       coord_y_o;
  logic [6:0]       result_o;
  logic             valid_o;
  logic             busy_o;

  set_scheduler #(.CMD_W(CMD_W)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_i       (cmd_i),
    .eng_start_o (eng_start_o),
    .eng_cmd_o   (eng_cmd_o),
    .coord_en_o  (coord_en_o),
    .coord_x_o   (coord_x_o),
    .coord_y_o   (coord_y_o),
    .hit_i       (hit_i),
    .result_o    (result_o),
    .valid_o     (valid_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [CMD_W-1:0] cmd;
    int               res;
    int               due;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   mode = 0;
  int   exp_idx = 0;
  int   last_due = -1000;

  always @(posedge clk_i) cyc++;

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Ten hand-picked grid indices (y*8+x) that the fake engine reports as hits.
  function automatic logic in_set(input int i);
    return i inside {0, 7, 9, 19, 26, 36, 46, 53, 56, 63};
  endfunction

  // Fake engine: outside SCAN hit_i is held high so any counting there shows up.
  always @(negedge clk_i) begin
    if (coord_en_o) begin
      case (mode)
        0:       hit_i = 1'b0;
        1:       hit_i = 1'b1;
        default: hit_i = in_set(int'({coord_y_o, coord_x_o}));
      endcase
    end else begin
      hit_i = 1'b1;
    end
  end

  // Monitor: compares DUT activity against the scoreboard head.
  always @(negedge clk_i) begin : monitor
    exp_t e;
    if (rst_ni) begin
      if (coord_en_o) begin
        chk("raster_order", int'({coord_y_o, coord_x_o}), exp_idx);
        exp_idx++;
      end
      if (eng_start_o) begin
        if (sb.size() == 0) begin
          chk("unexpected_start", 1, 0);
        end else begin
          chk("start_cycle", cyc, sb[0].due - 65);
          chk("start_cmd", int'(eng_cmd_o), int'(sb[0].cmd));
        end
        exp_idx = 0;
      end
`ifndef SET_SCHED_FIFO_EN
      if (busy_o) chk("ready_while_busy", int'(cmd_ready_o), 0);
`endif
      if (valid_o) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("result", int'(result_o), e.res);
          chk("valid_cycle", cyc, e.due);
          chk("done_cmd", int'(eng_cmd_o), int'(e.cmd));
          chk("scan_length", exp_idx, 64);
        end
      end else if (sb.size() > 0 && cyc > sb[0].due) begin
        chk("missing_valid", 0, 1);
        void'(sb.pop_front());
      end
    end
  end

  // Offer a command until accepted; records the acceptance cycle and the
  // expected completion (67 cycles after acceptance, or 67 after the previous
  // completion when the engine is still busy).
  task automatic send(input logic [CMD_W-1:0] c, input int r, output int n);
    int t;
    int due;
    n = -1;
    t = 0;
    @(negedge clk_i);
    cmd_i = c;
    cmd_valid_i = 1'b1;
    while (n < 0 && t < 500) begin
      if (cmd_ready_o) begin
        n = cyc;
        due = (n + 67 > last_due + 67) ? n + 67 : last_due + 67;
        last_due = due;
        sb.push_back('{cmd: c, res: r, due: due});
        @(posedge clk_i);
      end else begin
        @(negedge clk_i);
        t++;
      end
    end
    if (n < 0) chk("accept_timeout", 0, 1);
  endtask

  task automatic drop();
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() > 0 && t < 1000) begin
      @(negedge clk_i);
      t++;
    end
    chk("drain", sb.size(), 0);
  endtask

  task automatic reset_outputs(input string tag);
    chk({tag, "_eng_start"}, int'(eng_start_o), 0);
    chk({tag, "_eng_cmd"}, int'(eng_cmd_o), 0);
    chk({tag, "_coord_en"}, int'(coord_en_o), 0);
    chk({tag, "_coord_x"}, int'(coord_x_o), 0);
    chk({tag, "_coord_y"}, int'(coord_y_o), 0);
    chk({tag, "_result"}, int'(result_o), 0);
    chk({tag, "_valid"}, int'(valid_o), 0);
    chk({tag, "_busy"}, int'(busy_o), 0);
    chk({tag, "_ready"}, int'(cmd_ready_o), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0, n1, n2, n3, t;

    // Reset state and ready rising one cycle after release.
    repeat (3) @(negedge clk_i);
    reset_outputs("rst");
    rst_ni = 1'b1;
    #1;
    chk("ready_before_edge", int'(cmd_ready_o), 0);
    @(negedge clk_i);
    chk("ready_after_release", int'(cmd_ready_o), 1);
    chk("idle_busy", int'(busy_o), 0);

    // Ten chosen hits.
    mode = 2;
    send(16'hA5A5, 10, n0);
    drop();
    drain();

    // All hits: full 64 without wrap.
    mode = 1;
    send(16'h3C3C, 64, n0);
    drop();
    drain();

    // No hits inside SCAN (hit_i high elsewhere must be ignored).
    mode = 0;
    send(16'h0001, 0, n0);
    drop();
    drain();

`ifdef SET_SCHED_FIFO_EN
    // Engine busy with one command, then five pushed back-to-back.
    mode = 2;
    send(16'h1111, 10, n0);
    drop();
    t = 0;
    while (!eng_start_o && t < 50) begin
      @(negedge clk_i);
      t++;
    end
    chk("warm_start_seen", int'(eng_start_o), 1);
    send(16'h2222, 10, n0);
    send(16'h3333, 10, n1);
    send(16'h4444, 10, n2);
    send(16'h5555, 10, n3);
    @(negedge clk_i);
    chk("ready_full", int'(cmd_ready_o), 0);
    chk("accept_burst", n3 - n0, 3);
    send(16'h6666, 10, n0);
    drop();
    drain();
`else
    // Valid held high: one acceptance per command, the next only after DONE
    // plus the idle accept cycle.
    mode = 1;
    send(16'h1234, 64, n0);
    send(16'h5678, 64, n1);
    send(16'h9ABC, 64, n2);
    drop();
    chk("accept_spacing_1", n1 - n0, 68);
    chk("accept_spacing_2", n2 - n1, 68);
    drain();
`endif

    // Reset at SCAN index 30 aborts the command.
    mode = 1;
    send(16'h0F0F, 64, n0);
`ifdef SET_SCHED_FIFO_EN
    send(16'hF0F0, 64, n1);
`endif
    drop();
    t = 0;
    do begin
      @(negedge clk_i);
      t++;
    end while (!(coord_en_o && {coord_y_o, coord_x_o} == 6'd30) && t < 200);
    chk("reach_idx30", int'(t < 200), 1);
    rst_ni = 1'b0;
    sb.delete();
    last_due = -1000;
    #1;
    reset_outputs("abort");
    @(negedge clk_i);
    @(negedge clk_i);
    chk("abort_hold_valid", int'(valid_o), 0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("abort_ready_after_release", int'(cmd_ready_o), 1);
    chk("abort_busy_after_release", int'(busy_o), 0);
    repeat (80) @(negedge clk_i);
    chk("abort_queue_lost", int'(busy_o), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
